// File: rtl/prbs_pkg.sv
`default_nettype none
// ============================================================================
// Module   : prbs_pkg
// Purpose  : Shared types and helpers for the PRBS generator family: one-step
//            LFSR function, primitive tap-mask table for ORDER 3..31 and a
//            bit-difference helper for sequence checkers.
// Revision : 1.0 - initial release
// ============================================================================
package prbs_pkg;

  // Registered one-cycle event strobes of the generator.
  typedef struct packed {
    logic period_done;
    logic lockup;
  } prbs_evt_t;

  // Primitive feedback masks indexed by ORDER. Bit i set means state[i] feeds
  // the XOR. Entries 0..2 are unused and left at zero.
  localparam logic [31:0] PRIM_TAPS [0:31] = '{
    32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0006,
    32'h0000_000C, 32'h0000_0014, 32'h0000_0030, 32'h0000_0060,
    32'h0000_00B8, 32'h0000_0110, 32'h0000_0240, 32'h0000_0500,
    32'h0000_0829, 32'h0000_100D, 32'h0000_2015, 32'h0000_6000,
    32'h0000_D008, 32'h0001_2000, 32'h0002_0400, 32'h0004_0023,
    32'h0009_0000, 32'h0014_0000, 32'h0030_0000, 32'h0042_0000,
    32'h00E1_0000, 32'h0120_0000, 32'h0200_0023, 32'h0400_0013,
    32'h0900_0000, 32'h1400_0000, 32'h2000_0029, 32'h4800_0000
  };

  // One Fibonacci step: shift left, parity of the tapped bits enters bit 0.
  function automatic logic [31:0] next_state(input logic [31:0] st,
                                             input logic [31:0] taps,
                                             input int unsigned order);
    logic        fb;
    logic [31:0] mask;
    fb   = ^(st & taps);
    mask = (order >= 32) ? '1 : ((32'd1 << order) - 32'd1);
    return ((st << 1) | {31'd0, fb}) & mask;
  endfunction

  // Number of bit positions in which two words differ.
  function automatic int unsigned bit_diff(input logic [31:0] a,
                                           input logic [31:0] b);
    return unsigned'($countones(a ^ b));
  endfunction

endpackage
`default_nettype wire

// File: rtl/prbs_deser.sv
`default_nettype none
// ============================================================================
// Module   : prbs_deser
// Purpose  : Serial-to-parallel packer. Collects OUT_W valid bits MSB-first
//            (oldest bit ends up in the MSB) and presents the word with a
//            one-cycle dout_vld strobe. clr discards a partial word.
// Revision : 1.0 - initial release
// ============================================================================
module prbs_deser
  import prbs_pkg::*;
#(
  parameter int unsigned OUT_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             in_vld,
  input  logic             in_bit,
  output logic [OUT_W-1:0] dout,
  output logic             dout_vld
);

  localparam int unsigned c_CNT_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(OUT_W - 1);

  logic [OUT_W-1:0]   r_sr;
  logic [c_CNT_W-1:0] r_cnt;
  logic [OUT_W-1:0]   r_dout;
  logic               r_vld;
  logic [OUT_W-1:0]   w_sr_next;

  // Shift-register next value; a 1-bit word is just the incoming bit.
  generate
    if (OUT_W == 1) begin : g_w1
      assign w_sr_next = in_bit;
    end else begin : g_wn
      assign w_sr_next = {r_sr[OUT_W-2:0], in_bit};
    end
  endgenerate

  // Pack bits, count to OUT_W and publish the completed word for one cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sr   <= '0;
      r_cnt  <= '0;
      r_dout <= '0;
      r_vld  <= 1'b0;
    end else begin
      r_vld <= 1'b0;
      if (clr) begin
        r_cnt <= '0;
      end else if (in_vld) begin
        r_sr <= w_sr_next;
        if (r_cnt == c_LAST) begin
          r_cnt  <= '0;
          r_dout <= w_sr_next;
          r_vld  <= 1'b1;
        end else begin
          r_cnt <= r_cnt + c_CNT_W'(1);
        end
      end
    end
  end

  assign dout     = r_dout;
  assign dout_vld = r_vld;

endmodule
`default_nettype wire

// File: rtl/prbs_gen.sv
`default_nettype none
// ============================================================================
// Module   : prbs_gen
// Purpose  : Parametrised m-sequence generator with enable, run-time seed
//            load, all-zero lock-up recovery, parallel word output and a
//            full-period marker. Serial bit m is pin-compatible with the
//            fixed-polynomial predecessor.
// Options  : PRBS_ERR_INJ_EN - adds err_inj input; inverts the emitted bit
//            (m and packed word) for a single advance, LFSR untouched.
// Revision : 1.0 - initial release
// ============================================================================
module prbs_gen
  import prbs_pkg::*;
#(
  parameter int unsigned      ORDER = 7,
  parameter logic [ORDER-1:0] TAPS  = 7'b1100000,
  parameter logic [ORDER-1:0] SEED  = 7'h01,
  parameter int unsigned      OUT_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             load,
`ifdef PRBS_ERR_INJ_EN
  input  logic             err_inj,
`endif
  input  logic [ORDER-1:0] seed,
  output logic             m,
  output logic [ORDER-1:0] state,
  output logic [OUT_W-1:0] dout,
  output logic             dout_vld,
  output logic             period_done,
  output logic             lockup
);

  logic [ORDER-1:0] r_state;
  logic [ORDER-1:0] r_start;
  logic [ORDER-1:0] r_step;
  logic             r_m;
  prbs_evt_t        r_evt;

  logic [ORDER-1:0] w_next;
  logic [ORDER-1:0] w_load_val;
  logic [ORDER-1:0] w_step_inc;
  logic             w_zero;
  logic             w_adv;
  logic             w_recover;
  logic             w_flip;
  logic             w_bit;

`ifdef PRBS_ERR_INJ_EN
  assign w_flip = err_inj;
`else
  assign w_flip = 1'b0;
`endif

  assign w_next     = ORDER'(next_state(32'(r_state), 32'(TAPS), ORDER));
  assign w_zero     = (r_state == '0);
  // A zero seed would lock the LFSR, so it is replaced by the reset seed.
  assign w_load_val = (seed == '0) ? SEED : seed;
  // A zero state is never shifted; the enable cycle is spent on recovery.
  assign w_adv      = en & ~load & ~w_zero;
  assign w_recover  = en & ~load & w_zero;
  assign w_bit      = w_next[ORDER-1] ^ w_flip;
  // Step counter sticks at all-ones instead of wrapping back onto zero.
  assign w_step_inc = (&r_step) ? r_step : r_step + 1'b1;

  // LFSR, start register, step counter, serial bit and event strobes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= SEED;
      r_start <= SEED;
      r_step  <= '0;
      r_m     <= SEED[ORDER-1];
      r_evt   <= '0;
    end else begin
      r_evt <= '0;
      if (load) begin
        r_state      <= w_load_val;
        r_start      <= w_load_val;
        r_step       <= '0;
        r_m          <= w_load_val[ORDER-1];
        r_evt.lockup <= (seed == '0);
      end else if (w_recover) begin
        r_state      <= SEED;
        r_m          <= SEED[ORDER-1];
        r_evt.lockup <= 1'b1;
      end else if (w_adv) begin
        r_state <= w_next;
        r_m     <= w_bit;
        if (w_next == r_start) begin
          r_step            <= '0;
          r_evt.period_done <= 1'b1;
        end else begin
          r_step <= w_step_inc;
        end
      end
    end
  end

  prbs_deser #(
    .OUT_W (OUT_W)
  ) u_deser (
    .clk      (clk),
    .rstn     (rstn),
    .clr      (load),
    .in_vld   (w_adv),
    .in_bit   (w_bit),
    .dout     (dout),
    .dout_vld (dout_vld)
  );

  assign m           = r_m;
  assign state       = r_state;
  assign period_done = r_evt.period_done;
  assign lockup      = r_evt.lockup;

endmodule
`default_nettype wire

// File: doc/prbs_gen.md
Name: prbs_gen

Overview:
- Parametrised maximal-length sequence (PRBS/m-sequence) generator; the successor to the fixed single-polynomial m-sequence source.
- Generalises order and feedback polynomial, and adds enable, run-time seed load and all-zero lock-up recovery.
- Adds a serial-to-parallel word output and a full-period marker.
- Sits in front of DAC/modulator test paths and link BER loopback; the serial bit `m` stays pin-compatible with the existing generator.

Parameters:
- ORDER, 7, LFSR length in bits (3..31).
- TAPS, 7'b1100000, feedback mask, ORDER bits; bit i set means state[i] is XORed into the feedback. The default is x^7+x^6+1, period 127.
- SEED, 7'h01, reset/recovery state, ORDER bits; must be non-zero.
- OUT_W, 8, parallel word width (1..32).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- en  in  1  advance the LFSR one step this cycle.
- load  in  1  load `seed` into the LFSR.
- seed  in  ORDER  run-time seed value.
- m  out  1  serial sequence bit, equal to state[ORDER-1] (registered).
- state  out  ORDER  current LFSR state.
- dout  out  OUT_W  packed word, oldest bit in the MSB.
- dout_vld  out  1  one-cycle strobe: `dout` is valid.
- period_done  out  1  one-cycle strobe: the state has returned to the start value.
- lockup  out  1  one-cycle strobe: an all-zero state was replaced by SEED.

Behaviour:
- Clock and reset: single clock domain clk; reset is asynchronous, active-low, on rstn. rstn is asserted asynchronously and released synchronously by the upstream reset synchroniser.
- Reset values:
  - state = SEED, so m = SEED[ORDER-1].
  - dout = 0; dout_vld, period_done and lockup = 0.
  - Bit counter = 0; start register = SEED; step counter = 0.
- Advance (en=1, load=0):
  - fb = XOR over i of (state[i] & TAPS[i]).
  - state <= {state[ORDER-2:0], fb}; m follows one cycle after the advance edge.
  - en=0 holds all state; strobes deassert.
- Load (load=1):
  - state <= seed and start register <= seed.
  - Step counter and bit counter clear; no shift occurs.
  - load has priority over en in the same cycle.
- Lock-up:
  - A loaded seed of 0 is replaced by SEED, and lockup pulses on the next cycle.
  - An all-zero state reached any other way is also forced to SEED on the next en, with lockup pulsing. This cannot happen with a primitive TAPS.
- Deserialiser:
  - Each advance shifts the new m (the post-advance state[ORDER-1]) into a shift register MSB-first.
  - The bit counter wraps at OUT_W.
  - On the cycle after the OUT_W-th advance: dout is updated and dout_vld=1 for exactly one cycle.
  - For OUT_W=1, dout_vld follows every advance by one cycle.
- Period:
  - The step counter (ORDER bits) increments per advance.
  - When the post-advance state equals the start register, period_done pulses for one cycle and the step counter clears.
  - For a primitive TAPS this happens every 2^ORDER-1 advances.
  - The step counter saturates at all-ones; no wrap-around alias.
- Reset mid-word: the partial word is discarded and the bit count restarts from 0.

Optional Feature:
- Macro PRBS_ERR_INJ_EN.
- When defined:
  - Adds input port `err_inj` (1 bit).
  - When err_inj=1 on an advance cycle, the emitted m and the bit packed into dout are inverted for that step only.
  - LFSR state is unaffected, so the sequence self-realigns.
- When undefined: the port is absent and the output is the pure sequence.

Decomposition:
- Package prbs_pkg holds:
  - Function next_state(state, taps).
  - Localparam table of primitive tap masks for ORDER 3..31.
  - Checker helper used by the bench.
- Sub-module prbs_deser (serial-to-parallel packer, parameter OUT_W, with in_vld/in_bit and dout/dout_vld) is natural and reused by the future checker.

Test Plan:
1. Reset, defaults (ORDER=7, SEED=7'h01), en=1 after rstn release -> state sequence 01,02,04,08,10,20,41; m=1 first seen after the 6th advance.
2. Continuous en for 254 cycles -> period_done pulses exactly at advance 127 and 254; no lockup.
3. load=1 with seed=7'h00 -> next cycle state=7'h01 and lockup=1 for one cycle. load=1 with en=1 and seed=7'h55 -> state=7'h55, no shift.
4. OUT_W=8, 16 advances with en toggling 1/0 -> dout_vld pulses twice, one cycle after the 8th and 16th advance; dout matches the reference model's bits MSB-first.
5. rstn asserted after 3 advances of a word -> all outputs return to reset values immediately; the next word needs a full 8 advances.
6. PRBS_ERR_INJ_EN: err_inj=1 on advance 10 -> exactly one bit of m/dout is inverted versus the model; state is identical to the model throughout.
